// File: rtl/seg_flick_scan.sv
// Four-digit common-anode seven-segment scan driver with per-digit flicking driven by an async 2 Hz input.
// Optional auto-stop after FLICK_LIMIT flicks is enabled by defining FLICK_TIMEOUT_EN.
module seg_flick_scan #(
    parameter int unsigned SCAN_DIV    = 2000,
    parameter int unsigned FLICK_LIMIT = 10
) (
    input  logic        clk_2MHz,
    input  logic        reset,
    input  logic        flick_in,
    input  logic [15:0] digit_data,
    input  logic [3:0]  blink_mask,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        blink_phase,
    output logic        phase_tick,
    output logic        blink_done
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       nibble_c;
    logic             blank_c;
    logic [3:0]       an_nxt_c;
    logic [6:0]       seg_nxt_c;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Two-flop resynchroniser; phase_tick flags every settled phase change
    always_ff @(posedge clk_2MHz or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            blink_phase <= 1'b0;
            phase_tick  <= 1'b0;
        end else begin
            sync1       <= flick_in;
            sync2       <= sync1;
            blink_phase <= sync2;
            phase_tick  <= sync2 ^ blink_phase;
        end
    end

    // Slot timer and digit index
    always_ff @(posedge clk_2MHz or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    // Blanked digits drop both anode and segments so nothing ghosts
    always_comb begin
        nibble_c  = digit_data[{digit_idx, 2'b00} +: 4];
        blank_c   = blink_en & blink_mask[digit_idx] & ~blink_phase & ~blink_done;
        an_nxt_c  = 4'hF;
        seg_nxt_c = 7'h7F;
        if (!blank_c) begin
            an_nxt_c  = ~(4'b0001 << digit_idx);
            seg_nxt_c = hex7(nibble_c);
        end
    end

    always_ff @(posedge clk_2MHz or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 7'h7F;
        end else begin
            an  <= an_nxt_c;
            seg <= seg_nxt_c;
        end
    end

`ifdef FLICK_TIMEOUT_EN
    localparam int unsigned FCNT_W = $clog2(FLICK_LIMIT + 1);

    logic [FCNT_W-1:0] flick_cnt;
    logic              rise_c;

    // Rising phase about to be registered: coincides with the phase_tick edge
    assign rise_c = sync2 & ~blink_phase;

    // Count visible-half entries; dropping blink_en re-arms and takes priority
    always_ff @(posedge clk_2MHz or posedge reset) begin
        if (reset) begin
            flick_cnt  <= '0;
            blink_done <= 1'b0;
        end else if (!blink_en) begin
            flick_cnt  <= '0;
            blink_done <= 1'b0;
        end else if (rise_c && !blink_done) begin
            flick_cnt <= flick_cnt + FCNT_W'(1);
            if (32'(flick_cnt) + 32'd1 >= 32'(FLICK_LIMIT))
                blink_done <= 1'b1;
        end
    end
`else
    logic unused_flick_limit;

    assign unused_flick_limit = ^32'(FLICK_LIMIT);
    assign blink_done         = 1'b0;
`endif

endmodule

// File: tb/tb_seg_flick_scan.sv
// Randomised self-checking bench for seg_flick_scan against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_seg_flick_scan;

    localparam int unsigned S     = 4;
    localparam int unsigned LIMIT = 2;

    logic        clk_2MHz = 1'b0;
    logic        reset = 1'b1;
    logic        flick_in = 1'b0;
    logic [15:0] digit_data = 16'h0000;
    logic [3:0]  blink_mask = 4'h0;
    logic        blink_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        blink_phase;
    logic        phase_tick;
    logic        blink_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg_flick_scan #(.SCAN_DIV(S), .FLICK_LIMIT(LIMIT)) dut (
        .clk_2MHz(clk_2MHz), .reset(reset), .flick_in(flick_in),
        .digit_data(digit_data), .blink_mask(blink_mask), .blink_en(blink_en),
        .an(an), .seg(seg), .blink_phase(blink_phase), .phase_tick(phase_tick),
        .blink_done(blink_done)
    );

    always #250 clk_2MHz = ~clk_2MHz;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: k = edges since reset release; digit shown at edge k is ((k-1)/S)%4,
    // blink_phase at edge k equals flick_in sampled two edges earlier.
    int         k = 0;
    logic       fq[$];
    logic       m_bp = 1'b0, m_tick = 1'b0, m_done = 1'b0;
    int         m_fcnt = 0;
    logic [3:0] exp_an = 4'hF;
    logic [6:0] exp_seg = 7'h7F;

    always @(posedge clk_2MHz or posedge reset) begin
        logic prev_bp, prev_done, blank;
        int d;
        if (reset) begin
            k = 0; fq.delete(); m_bp = 0; m_tick = 0; m_done = 0; m_fcnt = 0;
            exp_an = 4'hF; exp_seg = 7'h7F;
        end else begin
            prev_bp = m_bp; prev_done = m_done;
            k++;
            fq.push_back(flick_in);
            if (fq.size() > 3) void'(fq.pop_front());
            m_bp   = (fq.size() == 3) ? fq[0] : 1'b0;
            m_tick = (m_bp != prev_bp);
            d = ((k - 1) / S) % 4;
            blank = blink_en & blink_mask[d] & ~prev_bp & ~prev_done;
            exp_an  = blank ? 4'hF : ~(4'(1) << d);
            exp_seg = blank ? 7'h7F : hex_tbl[digit_data[4*d +: 4]];
`ifdef FLICK_TIMEOUT_EN
            if (!blink_en) begin
                m_fcnt = 0; m_done = 0;
            end else if (!prev_done && m_bp && !prev_bp) begin
                m_fcnt++;
                if (m_fcnt >= LIMIT) m_done = 1;
            end
`endif
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_2MHz);
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || blink_phase !== 1'b0 || phase_tick !== 1'b0 || blink_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: an=%b seg=%b ph=%b tick=%b done=%b, want 1111 1111111 0 0 0", an, seg, blink_phase, phase_tick, blink_done);
        end
        reset = 1'b0;
        @(negedge clk_2MHz);
        n_checks++;
        if (an !== 4'b1110) begin
            n_fail++;
            $display("FAIL first_digit0: an=%b want 1110", an);
        end
    endtask

    task automatic test_scan();
        digit_data = 16'h1234; blink_en = 1'b0;
        for (int i = 0; i < 8 * S; i++) begin
            @(negedge clk_2MHz);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL scan k=%0d: an=%b seg=%b want an=%b seg=%b", k, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_hex();
        logic [15:0] pats [4] = '{16'hFEDC, 16'h3210, 16'h7654, 16'hBA98};
        for (int p = 0; p < 4; p++) begin
            digit_data = pats[p];
            for (int i = 0; i < 4 * S; i++) begin
                @(negedge clk_2MHz);
                n_checks++;
                if (an !== exp_an || seg !== exp_seg) begin
                    n_fail++;
                    $display("FAIL hex k=%0d: an=%b seg=%b want an=%b seg=%b", k, an, seg, exp_an, exp_seg);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_2MHz);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL hex_rand k=%0d: an=%b seg=%b want an=%b seg=%b", k, an, seg, exp_an, exp_seg);
            end
            digit_data = 16'($urandom);
        end
    endtask

    task automatic test_flick_sync();
        logic [1:0] want_ph [4] = '{2'b00, 2'b00, 2'b11, 2'b10};
        blink_en = 1'b0; flick_in = 1'b0;
        repeat (4) @(negedge clk_2MHz);
        flick_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_2MHz);
            n_checks++;
            if ({blink_phase, phase_tick} !== want_ph[i]) begin
                n_fail++;
                $display("FAIL sync_latency edge+%0d: ph,tick=%b%b want %b", i, blink_phase, phase_tick, want_ph[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) flick_in = ~flick_in;
            @(negedge clk_2MHz);
            n_checks++;
            if (blink_phase !== m_bp || phase_tick !== m_tick) begin
                n_fail++;
                $display("FAIL sync k=%0d: ph=%b tick=%b want ph=%b tick=%b", k, blink_phase, phase_tick, m_bp, m_tick);
            end
        end
    endtask

    task automatic test_blank();
        blink_en = 1'b1; blink_mask = 4'b0001; digit_data = 16'h1234;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) flick_in = ~flick_in;
            if (i >= 100 && $urandom_range(0, 7) == 0) blink_mask = 4'($urandom);
            if (i >= 100 && $urandom_range(0, 15) == 0) blink_en = ~blink_en;
            @(negedge clk_2MHz);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || blink_phase !== m_bp || blink_done !== m_done) begin
                n_fail++;
                $display("FAIL blank k=%0d: an=%b seg=%b ph=%b done=%b want an=%b seg=%b ph=%b done=%b",
                         k, an, seg, blink_phase, blink_done, exp_an, exp_seg, m_bp, m_done);
            end
        end
        // Drop enable during a blank half: masked digit must come back on the next update
        blink_en = 1'b1; blink_mask = 4'hF; flick_in = 1'b0;
        repeat (6) @(negedge clk_2MHz);
        blink_en = 1'b0;
        @(negedge clk_2MHz);
        n_checks++;
        if (an === 4'hF || an !== exp_an || seg !== exp_seg) begin
            n_fail++;
            $display("FAIL en_drop: an=%b seg=%b want an=%b seg=%b", an, seg, exp_an, exp_seg);
        end
    endtask

    task automatic test_timeout();
        logic want_done;
`ifdef FLICK_TIMEOUT_EN
        want_done = 1'b1;
`else
        want_done = 1'b0;
`endif
        blink_en = 1'b0; blink_mask = 4'hF; flick_in = 1'b0;
        @(negedge clk_2MHz);
        blink_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 80; i++) begin
                if (i % 6 == 5) flick_in = ~flick_in;
                @(negedge clk_2MHz);
                n_checks++;
                if (an !== exp_an || seg !== exp_seg || blink_done !== m_done) begin
                    n_fail++;
                    $display("FAIL timeout k=%0d: an=%b seg=%b done=%b want an=%b seg=%b done=%b",
                             k, an, seg, blink_done, exp_an, exp_seg, m_done);
                end
            end
            n_checks++;
            if (blink_done !== want_done) begin
                n_fail++;
                $display("FAIL done_level round %0d: done=%b want %b", r, blink_done, want_done);
            end
            blink_en = 1'b0;
            @(negedge clk_2MHz);
            blink_en = 1'b1;
            n_checks++;
            if (blink_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rearm: done=%b want 0", blink_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        blink_en = 1'b0; digit_data = 16'hA5C3;
        while (!(((k / S) % 4 == 2) && (k % S == 1)) && guard < 100) begin
            @(negedge clk_2MHz);
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL reset_mid_wait: digit 2 slot not reached, k=%0d", k);
        end
        n_checks++;
        if (an !== 4'b1011) begin
            n_fail++;
            $display("FAIL reset_mid_pre: an=%b want 1011", an);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            n_fail++;
            $display("FAIL reset_async: an=%b seg=%b want 1111 1111111", an, seg);
        end
        @(negedge clk_2MHz);
        reset = 1'b0;
        for (int i = 0; i < 4 * S; i++) begin
            @(negedge clk_2MHz);
            n_checks++;
            if (an !== ((i < S) ? 4'b1110 : exp_an) || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL reset_restart i=%0d: an=%b seg=%b want an=%b seg=%b", i, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hex();
        test_flick_sync();
        test_blank();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
